tank_damage_ctrl: RTL and testbench

Player-side damage and scoring controller. Each frame it checks every enemy bullet against the player tank box. It returns the `hit` and `tank_detroyed` signals that the enemy and enemy-bullet blocks consume, and runs the tank's explosion, respawn and invulnerability sequence. It also keeps the lives and kill-score counters for the HUD.

---
 rtl/tank_game_pkg.sv | 34 +++
 rtl/tank_damage_ctrl_box_overlap.sv | 17 +
 rtl/tank_damage_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tank_damage_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_game_pkg.sv
// Shared types and geometry for the tank game datapath.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package tank_game_pkg;

  // Damage controller states.
  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_BOOM   = 2'd1,
    ST_INVULN = 2'd2,
    ST_OVER   = 2'd3
  } dmg_state_t;

  // Sprite sizes in pixels.
  localparam int TANK_SIZE   = 32;
  localparam int BULLET_SIZE = 4;

  // Playfield limits in pixels.
  localparam int X_LEFT   = 32;
  localparam int X_RIGHT  = 608;
  localparam int Y_TOP    = 32;
  localparam int Y_BOTTOM = 448;

  // One-axis overlap of a bullet span [pb, pb+3] against a tank span
  // [pt, pt+31]. Evaluated in 11 bits so pt+32 cannot wrap at 1023.
  function automatic logic span_overlap(input logic [9:0] pb, input logic [9:0] pt);
    logic [10:0] b;
    logic [10:0] t;
    b = {1'b0, pb};
    t = {1'b0, pt};
    return (b < t + 11'(TANK_SIZE)) && (b + 11'(BULLET_SIZE - 1) >= t);
  endfunction

endpackage

// File: rtl/tank_damage_ctrl_box_overlap.sv
// Combinational 4x4 bullet box vs 32x32 tank box overlap detector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: xb_i/yb_i bullet top-left, xt_i/yt_i tank top-left, ovl_o overlap flag.
module box_overlap
  import tank_game_pkg::*;
(
  input  logic [9:0] xb_i,
  input  logic [9:0] yb_i,
  input  logic [9:0] xt_i,
  input  logic [9:0] yt_i,
  output logic       ovl_o
);

  assign ovl_o = span_overlap(xb_i, xt_i) && span_overlap(yb_i, yt_i);

endmodule

// File: rtl/tank_damage_ctrl.sv
// Player tank damage, respawn/invulnerability sequencing, lives and kill score.
// Latency: all outputs registered; a detection on tick cycle T shows at T+1.
// Backpressure: none; state only advances on refresh_tick, other cycles hold.
// Ports: clk_50MHz/reset (async, active-high), refresh_tick frame strobe,
//   x_tank/y_tank tank corner, x/y_enemy_bullet packed bullet corners,
//   enemy_detroyed kill levels; hit per-bullet strike, tank_detroyed/tank_boom
//   explosion, tank_respawn 1-cycle pulse, tank_invuln, lives, score, game_over.
module tank_damage_ctrl
  import tank_game_pkg::*;
#(
  parameter int NUM_ENEMY     = 2,
  parameter int LIVES         = 3,
  parameter int BOOM_FRAMES   = 8,
  parameter int INVULN_FRAMES = 64
) (
  input  logic                    clk_50MHz,
  input  logic                    reset,
  input  logic                    refresh_tick,
  input  logic [9:0]              x_tank,
  input  logic [9:0]              y_tank,
  input  logic [NUM_ENEMY*10-1:0] x_enemy_bullet,
  input  logic [NUM_ENEMY*10-1:0] y_enemy_bullet,
  input  logic [NUM_ENEMY-1:0]    enemy_detroyed,
  output logic [NUM_ENEMY-1:0]    hit,
  output logic                    tank_detroyed,
  output logic                    tank_boom,
  output logic                    tank_respawn,
  output logic                    tank_invuln,
  output logic [2:0]              lives,
  output logic [7:0]              score,
  output logic                    game_over
);

  localparam int CNT_MAX = (BOOM_FRAMES > INVULN_FRAMES) ? BOOM_FRAMES : INVULN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // ---------------------------------------------------------------------------
  // Per-bullet overlap detection
  // ---------------------------------------------------------------------------
  logic [NUM_ENEMY-1:0] ovl;

  for (genvar gi = 0; gi < NUM_ENEMY; gi++) begin : g_ovl
    box_overlap u_box_overlap (
      .xb_i  (x_enemy_bullet[gi*10 +: 10]),
      .yb_i  (y_enemy_bullet[gi*10 +: 10]),
      .xt_i  (x_tank),
      .yt_i  (y_tank),
      .ovl_o (ovl[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  dmg_state_t           state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [2:0]           lives_q,   lives_d;
  logic [NUM_ENEMY-1:0] hit_q,     hit_d;
  logic                 boom_q,    boom_d;
  logic                 invuln_q,  invuln_d;
  logic                 over_q,    over_d;
  logic                 respawn_q, respawn_d;
  logic [NUM_ENEMY-1:0] ed_q,      ed_d;
  logic [7:0]           score_q,   score_d;

  // State register (FSM plus everything it owns).
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ALIVE;
      cnt_q     <= '0;
      lives_q   <= 3'(LIVES);
      hit_q     <= '0;
      boom_q    <= 1'b0;
      invuln_q  <= 1'b0;
      over_q    <= 1'b0;
      respawn_q <= 1'b0;
      ed_q      <= '0;
      score_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lives_q   <= lives_d;
      hit_q     <= hit_d;
      boom_q    <= boom_d;
      invuln_q  <= invuln_d;
      over_q    <= over_d;
      respawn_q <= respawn_d;
      ed_q      <= ed_d;
      score_q   <= score_d;
    end
  end

  // Next-state logic. Nothing moves outside tick cycles. Any tick clears hit
  // unless it is a fresh detection, so a hit vector is visible from the
  // detection tick up to and including the following tick cycle, which is
  // where the enemy bullet logic samples it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    hit_d   = hit_q;
    if (refresh_tick) begin
      hit_d = '0;
      unique case (state_q)
        ST_ALIVE: begin
          if (|ovl) begin
            hit_d   = ovl;
            // One life per frame no matter how many bullets landed.
            lives_d = lives_q - 3'd1;
            cnt_d   = '0;
            state_d = ST_BOOM;
          end
        end
        ST_BOOM: begin
          if (cnt_q == CNT_W'(BOOM_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = (lives_q == 3'd0) ? ST_OVER : ST_INVULN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_INVULN: begin
          // Overlaps on the final invulnerable tick are deliberately dropped.
          if (cnt_q == CNT_W'(INVULN_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = ST_ALIVE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_ALIVE;
        end
      endcase
    end
  end

  // Output logic: computed from the upcoming state so the registered outputs
  // line up with state_q. The respawn pulse marks the BOOM->INVULN transition,
  // which only exists on a tick cycle, so it lasts exactly one clock.
  always_comb begin
    boom_d    = (state_d == ST_BOOM) || (state_d == ST_OVER);
    invuln_d  = (state_d == ST_INVULN);
    over_d    = (state_d == ST_OVER);
    respawn_d = (state_q == ST_BOOM) && (state_d == ST_INVULN);
  end

  // ---------------------------------------------------------------------------
  // Kill score: rising edges of enemy_detroyed sampled on ticks, saturating.
  // ---------------------------------------------------------------------------
  logic [NUM_ENEMY-1:0] rise;
  logic [8:0]           pop;
  logic [8:0]           sum;

  always_comb begin
    rise = enemy_detroyed & ~ed_q;
    pop  = '0;
    for (int i = 0; i < NUM_ENEMY; i++) begin
      pop = pop + 9'(rise[i]);
    end
    sum     = {1'b0, score_q} + pop;
    ed_d    = ed_q;
    score_d = score_q;
    if (refresh_tick) begin
      ed_d = enemy_detroyed;
      if (state_q != ST_OVER) begin
        score_d = (sum > 9'd255) ? 8'hFF : sum[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign hit           = hit_q;
  assign tank_detroyed = boom_q;
  assign tank_boom     = boom_q;
  assign tank_respawn  = respawn_q;
  assign tank_invuln   = invuln_q;
  assign lives         = lives_q;
  assign score         = score_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_tank_damage_ctrl.sv
// Directed bench for tank_damage_ctrl: hit detection, boundaries, sequencing,
// game over, score counting/saturation and asynchronous reset.
module tb_tank_damage_ctrl;

  localparam int NE = 2;

  logic              clk_50MHz = 1'b0;
  logic              reset = 1'b1;
  logic              refresh_tick = 1'b0;
  logic [9:0]        x_tank = 10'd100;
  logic [9:0]        y_tank = 10'd100;
  logic [NE*10-1:0]  x_enemy_bullet = '0;
  logic [NE*10-1:0]  y_enemy_bullet = '0;
  logic [NE-1:0]     enemy_detroyed = '0;
  logic [NE-1:0]     hit;
  logic              tank_detroyed;
  logic              tank_boom;
  logic              tank_respawn;
  logic              tank_invuln;
  logic [2:0]        lives;
  logic [7:0]        score;
  logic              game_over;

  int vecs = 0;
  int errs = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  tank_damage_ctrl #(
    .NUM_ENEMY     (NE),
    .LIVES         (3),
    .BOOM_FRAMES   (8),
    .INVULN_FRAMES (64)
  ) dut (
    .clk_50MHz      (clk_50MHz),
    .reset          (reset),
    .refresh_tick   (refresh_tick),
    .x_tank         (x_tank),
    .y_tank         (y_tank),
    .x_enemy_bullet (x_enemy_bullet),
    .y_enemy_bullet (y_enemy_bullet),
    .enemy_detroyed (enemy_detroyed),
    .hit            (hit),
    .tank_detroyed  (tank_detroyed),
    .tank_boom      (tank_boom),
    .tank_respawn   (tank_respawn),
    .tank_invuln    (tank_invuln),
    .lives          (lives),
    .score          (score),
    .game_over      (game_over)
  );

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk_50MHz);
    refresh_tick = 1'b1;
    @(negedge clk_50MHz);
    refresh_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_bullet(input int idx, input int x, input int y);
    x_enemy_bullet[idx*10 +: 10] = 10'(x);
    y_enemy_bullet[idx*10 +: 10] = 10'(y);
  endtask

  task automatic park_bullets();
    set_bullet(0, 500, 400);
    set_bullet(1, 500, 400);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    refresh_tick = 1'b0;
    enemy_detroyed = '0;
    x_tank = 10'd100;
    y_tank = 10'd100;
    park_bullets();
    repeat (2) @(negedge clk_50MHz);
    reset = 1'b0;
    @(negedge clk_50MHz);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    vecs++; if (hit !== 2'b00) begin errs++; $display("FAIL rst_hit: got %b want 00", hit); end
    vecs++; if (tank_detroyed !== 1'b0 || tank_boom !== 1'b0) begin errs++; $display("FAIL rst_boom: got %b/%b want 0/0", tank_detroyed, tank_boom); end
    vecs++; if (tank_respawn !== 1'b0 || tank_invuln !== 1'b0) begin errs++; $display("FAIL rst_resp_inv: got %b/%b want 0/0", tank_respawn, tank_invuln); end
    vecs++; if (lives !== 3'd3) begin errs++; $display("FAIL rst_lives: got %0d want 3", lives); end
    vecs++; if (score !== 8'd0) begin errs++; $display("FAIL rst_score: got %0d want 0", score); end
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL rst_over: got %b want 0", game_over); end
  endtask

  task automatic test_single_hit();
    apply_reset();
    set_bullet(0, 130, 120);
    repeat (3) @(negedge clk_50MHz);
    vecs++; if (hit !== 2'b00 || lives !== 3'd3) begin errs++; $display("FAIL no_tick_ignored: got hit=%b lives=%0d want 00/3", hit, lives); end
    tick();
    vecs++; if (hit !== 2'b01) begin errs++; $display("FAIL single_hit: got %b want 01", hit); end
    vecs++; if (lives !== 3'd2) begin errs++; $display("FAIL single_lives: got %0d want 2", lives); end
    vecs++; if (tank_detroyed !== 1'b1 || tank_boom !== 1'b1) begin errs++; $display("FAIL single_boom: got %b/%b want 1/1", tank_detroyed, tank_boom); end
    park_bullets();
    // hit must still be visible during the next tick cycle
    @(negedge clk_50MHz);
    refresh_tick = 1'b1;
    #1;
    vecs++; if (hit !== 2'b01) begin errs++; $display("FAIL hit_held: got %b want 01", hit); end
    @(negedge clk_50MHz);
    refresh_tick = 1'b0;
    vecs++; if (hit !== 2'b00) begin errs++; $display("FAIL hit_clear: got %b want 00", hit); end
    for (int k = 2; k <= 7; k++) begin
      tick();
      vecs++; if (tank_detroyed !== 1'b1 || tank_respawn !== 1'b0) begin errs++; $display("FAIL boom_tick%0d: got det=%b resp=%b want 1/0", k, tank_detroyed, tank_respawn); end
    end
    tick();
    vecs++; if (tank_detroyed !== 1'b0 || tank_boom !== 1'b0) begin errs++; $display("FAIL boom_end: got %b/%b want 0/0", tank_detroyed, tank_boom); end
    vecs++; if (tank_respawn !== 1'b1 || tank_invuln !== 1'b1) begin errs++; $display("FAIL respawn_rise: got resp=%b inv=%b want 1/1", tank_respawn, tank_invuln); end
    @(negedge clk_50MHz);
    vecs++; if (tank_respawn !== 1'b0 || tank_invuln !== 1'b1) begin errs++; $display("FAIL respawn_pulse: got resp=%b inv=%b want 0/1", tank_respawn, tank_invuln); end
    ticks(63);
    vecs++; if (tank_invuln !== 1'b1) begin errs++; $display("FAIL invuln_63: got %b want 1", tank_invuln); end
    tick();
    vecs++; if (tank_invuln !== 1'b0) begin errs++; $display("FAIL invuln_end: got %b want 0", tank_invuln); end
  endtask

  task automatic test_boundaries();
    int          xs   [4] = '{132, 131, 96, 97};
    logic [1:0]  want [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      set_bullet(0, xs[i], 120);
      tick();
      vecs++; if (hit !== want[i]) begin errs++; $display("FAIL edge_x%0d: got %b want %b", xs[i], hit, want[i]); end
    end
  endtask

  task automatic test_double_hit();
    apply_reset();
    set_bullet(0, 130, 120);
    set_bullet(1, 110, 110);
    tick();
    vecs++; if (hit !== 2'b11) begin errs++; $display("FAIL double_hit: got %b want 11", hit); end
    vecs++; if (lives !== 3'd2) begin errs++; $display("FAIL double_lives: got %0d want 2", lives); end
  endtask

  task automatic test_invuln();
    int bad = 0;
    apply_reset();
    set_bullet(0, 130, 120);
    tick();
    ticks(8);
    vecs++; if (tank_invuln !== 1'b1 || lives !== 3'd2) begin errs++; $display("FAIL inv_enter: got inv=%b lives=%0d want 1/2", tank_invuln, lives); end
    for (int k = 1; k <= 64; k++) begin
      if (k == 10) enemy_detroyed = 2'b01;
      tick();
      if (hit !== 2'b00 || lives !== 3'd2) bad++;
    end
    vecs++; if (bad != 0) begin errs++; $display("FAIL inv_ignore: got %0d bad ticks want 0", bad); end
    vecs++; if (tank_invuln !== 1'b0) begin errs++; $display("FAIL inv_done: got %b want 0", tank_invuln); end
    vecs++; if (score !== 8'd1) begin errs++; $display("FAIL inv_score: got %0d want 1", score); end
    tick();
    vecs++; if (hit !== 2'b01 || lives !== 3'd1) begin errs++; $display("FAIL inv_rehit: got hit=%b lives=%0d want 01/1", hit, lives); end
  endtask

  task automatic test_game_over();
    apply_reset();
    set_bullet(0, 130, 120);
    for (int h = 1; h <= 3; h++) begin
      tick();
      vecs++; if (lives !== 3'(3 - h)) begin errs++; $display("FAIL go_lives%0d: got %0d want %0d", h, lives, 3 - h); end
      ticks(7);
      tick();
      if (h < 3) begin
        vecs++; if (tank_respawn !== 1'b1) begin errs++; $display("FAIL go_resp%0d: got %b want 1", h, tank_respawn); end
        ticks(64);
      end else begin
        vecs++; if (game_over !== 1'b1 || lives !== 3'd0) begin errs++; $display("FAIL go_enter: got over=%b lives=%0d want 1/0", game_over, lives); end
        vecs++; if (tank_respawn !== 1'b0 || tank_invuln !== 1'b0) begin errs++; $display("FAIL go_no_resp: got resp=%b inv=%b want 0/0", tank_respawn, tank_invuln); end
        vecs++; if (tank_detroyed !== 1'b1) begin errs++; $display("FAIL go_det: got %b want 1", tank_detroyed); end
      end
    end
    @(negedge clk_50MHz);
    vecs++; if (tank_respawn !== 1'b0) begin errs++; $display("FAIL go_no_resp2: got %b want 0", tank_respawn); end
    enemy_detroyed = 2'b11; tick();
    enemy_detroyed = 2'b00; tick();
    enemy_detroyed = 2'b11; tick();
    vecs++; if (score !== 8'd0 || lives !== 3'd0) begin errs++; $display("FAIL go_frozen: got score=%0d lives=%0d want 0/0", score, lives); end
    vecs++; if (hit !== 2'b00 || game_over !== 1'b1 || tank_detroyed !== 1'b1) begin errs++; $display("FAIL go_sticky: got hit=%b over=%b det=%b want 00/1/1", hit, game_over, tank_detroyed); end
  endtask

  task automatic test_score();
    apply_reset();
    enemy_detroyed = 2'b11;
    @(negedge clk_50MHz);
    enemy_detroyed = 2'b00;
    tick();
    vecs++; if (score !== 8'd0) begin errs++; $display("FAIL sc_no_tick: got %0d want 0", score); end
    enemy_detroyed = 2'b11; tick();
    vecs++; if (score !== 8'd2) begin errs++; $display("FAIL sc_both: got %0d want 2", score); end
    ticks(4);
    vecs++; if (score !== 8'd2) begin errs++; $display("FAIL sc_held: got %0d want 2", score); end
    enemy_detroyed = 2'b00; tick();
    vecs++; if (score !== 8'd2) begin errs++; $display("FAIL sc_fall: got %0d want 2", score); end
    enemy_detroyed = 2'b01; tick();
    vecs++; if (score !== 8'd3) begin errs++; $display("FAIL sc_one: got %0d want 3", score); end
    enemy_detroyed = 2'b11; tick();
    vecs++; if (score !== 8'd4) begin errs++; $display("FAIL sc_other: got %0d want 4", score); end
    enemy_detroyed = 2'b00; tick();
    for (int i = 0; i < 125; i++) begin
      enemy_detroyed = 2'b11; tick();
      enemy_detroyed = 2'b00; tick();
    end
    vecs++; if (score !== 8'd254) begin errs++; $display("FAIL sc_254: got %0d want 254", score); end
    enemy_detroyed = 2'b11; tick();
    vecs++; if (score !== 8'd255) begin errs++; $display("FAIL sc_sat: got %0d want 255", score); end
    enemy_detroyed = 2'b00; tick();
    enemy_detroyed = 2'b11; tick();
    vecs++; if (score !== 8'd255) begin errs++; $display("FAIL sc_sat_hold: got %0d want 255", score); end
  endtask

  task automatic test_reset_mid();
    int resp_seen = 0;
    // mid-BOOM
    apply_reset();
    set_bullet(0, 130, 120);
    tick();
    park_bullets();
    ticks(3);
    @(negedge clk_50MHz);
    #3 reset = 1'b1;
    #1;
    vecs++; if (tank_detroyed !== 1'b0 || lives !== 3'd3 || hit !== 2'b00) begin errs++; $display("FAIL rst_mid_boom: got det=%b lives=%0d hit=%b want 0/3/00", tank_detroyed, lives, hit); end
    @(negedge clk_50MHz);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tank_respawn !== 1'b0 || tank_detroyed !== 1'b0) resp_seen++;
    end
    vecs++; if (resp_seen != 0) begin errs++; $display("FAIL rst_no_pending: got %0d bad ticks want 0", resp_seen); end
    // mid-INVULN
    set_bullet(0, 130, 120);
    tick();
    park_bullets();
    ticks(8 + 5);
    vecs++; if (tank_invuln !== 1'b1) begin errs++; $display("FAIL rst_pre_inv: got %b want 1", tank_invuln); end
    @(negedge clk_50MHz);
    #3 reset = 1'b1;
    #1;
    vecs++; if (tank_invuln !== 1'b0 || lives !== 3'd3) begin errs++; $display("FAIL rst_mid_inv: got inv=%b lives=%0d want 0/3", tank_invuln, lives); end
    @(negedge clk_50MHz);
    reset = 1'b0;
    set_bullet(0, 130, 120);
    tick();
    vecs++; if (hit !== 2'b01 || lives !== 3'd2) begin errs++; $display("FAIL rst_alive_again: got hit=%b lives=%0d want 01/2", hit, lives); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_boundaries();
    test_double_hit();
    test_invuln();
    test_game_over();
    test_score();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
